rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Example resource: a single bus or port slot that priority-encoder-selected sources contend for.
- Out of reset it behaves like a fixed priority encoder: bit 7 highest.
- After each grant the priority rotates, giving bounded-wait fairness.
- Holds a grant until the owner signals done, drops its request, or exceeds a hold limit.

---
 rtl/rr_arbiter8_if.sv | 21 ++
 rtl/rr_arbiter8.sv | 113 +++++++++++
 tb/tb_rr_arbiter8.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The master side drives requests; the slave (arbiter) side returns the grant.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_v;
    logic       busy;
    logic       to_evt;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_v, busy, to_evt
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_v, busy, to_evt
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, bounded hold
// time and a mandatory dead cycle between owners.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter8_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    gnt_id_q, gnt_id_d;
    logic          gnt_v_q, gnt_v_d;
    logic          to_evt_q, to_evt_d;

    logic [2:0]    win_id;
    logic          rel_done, rel_drop, rel_to, release_now;

    // Scan runs from the farthest (ptr+1) to the nearest (ptr) so the last hit,
    // i.e. the one closest to ptr going downward, is the winner.
    always_comb begin
        win_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.req[ptr_q - 3'(i)]) begin
                win_id = ptr_q - 3'(i);
            end
        end
    end

    assign rel_done    = bus.done;
    assign rel_drop    = ~bus.req[gnt_id_q];
    assign rel_to      = (hold_cnt_q == CW'(MAX_HOLD));
    assign release_now = rel_done | rel_drop | rel_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd7;
            hold_cnt_q <= '0;
            gnt_q      <= 8'd0;
            gnt_id_q   <= 3'd0;
            gnt_v_q    <= 1'b0;
            to_evt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_v_q    <= gnt_v_d;
            to_evt_q   <= to_evt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_v_d    = gnt_v_q;
        to_evt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d    = GRANT;
                    gnt_d      = 8'd1 << win_id;
                    gnt_id_d   = win_id;
                    gnt_v_d    = 1'b1;
                    hold_cnt_d = CW'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d    = RELEASE;
                    gnt_d      = 8'd0;
                    gnt_v_d    = 1'b0;
                    hold_cnt_d = '0;
                    // Releasing owner drops to lowest priority next round.
                    ptr_d      = gnt_id_q - 3'd1;
                    to_evt_d   = rel_to & ~rel_done & ~rel_drop;
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.gnt    = gnt_q;
        bus.gnt_id = gnt_id_q;
        bus.gnt_v  = gnt_v_q;
        bus.busy   = (state_q != IDLE);
        bus.to_evt = to_evt_q;
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, rotation, timeout, request drop,
// done-vs-timeout priority and asynchronous reset mid-grant.
module tb_rr_arbiter8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(16), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                              input logic v, input logic b, input logic t);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        if (v) check({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(id));
        check({tag, ".gnt_v"}, 32'(bus.gnt_v), 32'(v));
        check({tag, ".busy"}, 32'(bus.busy), 32'(b));
        check({tag, ".to_evt"}, 32'(bus.to_evt), 32'(t));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.req  = 8'd0;
        bus.done = 1'b0;
        tick();
        tick();
        expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("reset.gnt_id", 32'(bus.gnt_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_out("idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Fixed-priority start: 2 beats 0, then 0 after rotation.
        bus.req = 8'b0000_0101;
        tick();
        expect_out("first_gnt", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        expect_out("first_rel", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b0;
        tick();
        expect_out("first_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("second_gnt", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        expect_out("second_rel", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b0;

        // All requesting: rotation 7..0 then 7, three cycles per grant.
        bus.req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            automatic logic [2:0] id = 3'(7 - (k % 8));
            tick();
            expect_out($sformatf("rr%0d_c1", k), 8'd1 << id, id, 1'b1, 1'b1, 1'b0);
            tick();
            check($sformatf("rr%0d_c2.gnt", k), 32'(bus.gnt), 32'(8'd1 << id));
            tick();
            check($sformatf("rr%0d_c3.gnt", k), 32'(bus.gnt), 32'(8'd1 << id));
            bus.done = 1'b1;
            tick();
            expect_out($sformatf("rr%0d_rel", k), 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
            bus.done = 1'b0;
            if (k == 8) bus.req = 8'b0001_0000;
            tick();
            expect_out($sformatf("rr%0d_idle", k), 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // Lone requester 4 without done: held exactly 16 cycles then timed out.
        for (int k = 1; k <= 16; k++) begin
            tick();
            expect_out($sformatf("hold%0d", k), 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);
        end
        tick();
        expect_out("timeout_rel", 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("timeout_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("regrant4", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);

        // Owner 5 drops its request while 1 waits.
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 8'b0010_0000;
        tick();
        tick();
        expect_out("gnt5", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
        bus.req = 8'b0000_0010;
        tick();
        expect_out("drop5_rel", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("drop5_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("gnt1", 8'h02, 3'd1, 1'b1, 1'b1, 1'b0);

        // done coincides with hold limit: ordinary release, no timeout pulse.
        repeat (15) tick();
        check("gnt1_c16.gnt", 32'(bus.gnt), 32'h02);
        bus.done = 1'b1;
        tick();
        expect_out("done_to_rel", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b0;

        // Asynchronous reset mid-grant; ptr (now 0) must return to 7.
        bus.req = 8'hFF;
        tick();
        tick();
        expect_out("gnt0", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_out("post_rst_gnt", 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
